// File: rtl/axis_pattern_gen.sv
// AXI-Stream counting-pattern source: frames of seed + k*step, optional frame count or graceful stop.
// tvalid rises 1 cycle after start; 1 beat/cycle under tready=1; tdata/tlast held while stalled.
module axis_pattern_gen #(
    parameter int LEN_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             m_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [LEN_W-1:0] num_frames,
    input  logic [31:0]      seed,
    input  logic [7:0]       step,
    output logic             busy,
    output logic             done,
    output logic [31:0]      word_count,
    output logic [31:0]      frame_count
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] nfr_q, nfr_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] frame_q, frame_d;
    logic [7:0]       step_q, step_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      word_cnt_q, word_cnt_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stop_pend_q, stop_pend_d;
    logic             hs;

    assign hs = tvalid_q & m_axis_tready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        nfr_d       = nfr_q;
        beat_d      = beat_q;
        frame_d     = frame_q;
        step_d      = step_q;
        data_d      = data_q;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A zero frame length degenerates to single-beat frames.
                    len_d       = (frame_len == '0) ? LEN_W'(1) : frame_len;
                    nfr_d       = num_frames;
                    step_d      = step;
                    data_d      = seed;
                    word_cnt_d  = '0;
                    frame_cnt_d = '0;
                    beat_d      = '0;
                    frame_d     = '0;
                    stop_pend_d = 1'b0;
                    tlast_d     = (frame_len <= LEN_W'(1));
                    tvalid_d    = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (hs) begin
                    data_d     = data_q + {24'd0, step_q};
                    word_cnt_d = word_cnt_q + 32'd1;
                    if (tlast_q) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        beat_d      = '0;
                        frame_d     = frame_q + LEN_W'(1);
                        // Same-cycle stop counts as pending; a count limit wins regardless.
                        if (((nfr_q != '0) && (frame_d == nfr_q)) || stop_pend_q || stop) begin
                            state_d     = S_DONE;
                            tvalid_d    = 1'b0;
                            tlast_d     = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            tlast_d = (len_q == LEN_W'(1));
                        end
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        tlast_d = ((beat_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            nfr_q       <= '0;
            beat_q      <= '0;
            frame_q     <= '0;
            step_q      <= '0;
            data_q      <= '0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nfr_q       <= nfr_d;
            beat_q      <= beat_d;
            frame_q     <= frame_d;
            step_q      <= step_d;
            data_q      <= data_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign word_count    = word_cnt_q;
    assign frame_count   = frame_cnt_q;

endmodule
